// File: rtl/cpuc_seq_ctrl_pkg.sv
// cpuc_package: shared types and constants for the cpuc control sequencer.
//   t_cpuc_op    - instruction opcodes (8..15 are illegal)
//   t_cpuc_instr - fixed 32-bit instruction word layout
//   t_seq_state  - sequencer FSM states
//   ADDER_IDX / GREATER_IDX / EQUAL_IDX - grid component indices of the
//   functional units for the default register count; the sequencer derives
//   its own indices as offsets from these so other register counts still work.
//   cpuc_illegal() - legality check applied in DECODE.
package cpuc_package;

    localparam int unsigned CPUC_NUM_REGS = 8;
    localparam int unsigned ADDER_IDX     = CPUC_NUM_REGS;
    localparam int unsigned GREATER_IDX   = CPUC_NUM_REGS + 1;
    localparam int unsigned EQUAL_IDX     = CPUC_NUM_REGS + 2;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_GT   = 4'd3,
        OP_EQ   = 4'd4,
        OP_JMP  = 4'd5,
        OP_BNZ  = 4'd6,
        OP_HALT = 4'd7
    } t_cpuc_op;

    // op is kept as raw bits: illegal encodings must be representable.
    typedef struct packed {
        logic [3:0] op;
        logic [7:0] dst;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rsvd;
    } t_cpuc_instr;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_DONE   = 3'd4
    } t_seq_state;

    // Returns 1 when the instruction cannot be executed: unknown opcode or a
    // register field that names a non-existent register for that opcode.
    function automatic logic cpuc_illegal(input t_cpuc_instr ins, input logic [7:0] nregs);
        logic bad;
        bad = 1'b0;
        case (ins.op)
            OP_NOP, OP_JMP, OP_HALT: bad = 1'b0;
            OP_MOV:                  bad = (ins.dst >= nregs) || (ins.a >= nregs);
            OP_ADD, OP_GT, OP_EQ:    bad = (ins.dst >= nregs) || (ins.a >= nregs) || (ins.b >= nregs);
            OP_BNZ:                  bad = (ins.a >= nregs);
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/cpuc_imem.sv
// cpuc_imem: instruction memory, one write port, one synchronous read port.
//   clk   - clock
//   we    - write strobe (gated by the caller)
//   waddr - write address
//   wdata - write data
//   raddr - read address, sampled on clk
//   rdata - mem[raddr] from the previous clock edge
// Contents are deliberately not reset.
module cpuc_imem #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpuc_seq_ctrl.sv
// cpuc_seq_ctrl: control sequencer for the cpuc grid. Steps a small program
// held in cpuc_imem (FETCH -> DECODE -> EXEC, 3 cycles per instruction) and
// drives the grid's register source selects, write enables and operand selects.
//   clk, rst (async, active low)
//   start / busy / done / error    - host launch handshake, error is sticky
//   imem_we / imem_waddr / imem_wdata - program load port, honoured only in IDLE
//   reg_in_sel[r]   - component index routed to register r's input
//   reg_wr_en[r]    - register r captures at the end of EXEC
//   op_in1_sel / op_in2_sel - register indices on the unit operand buses
//   cond_rd_sel / cond_rd_data - register readback used by BNZ
//   pc_out          - current program counter
module cpuc_seq_ctrl
    import cpuc_package::*;
#(
    parameter int unsigned NUM_OF_REGS = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned IMEM_DEPTH  = 64,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start,
    output logic                                             busy,
    output logic                                             done,
    output logic                                             error,
    input  logic                                             imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0]                    imem_waddr,
    input  logic [INSTR_WIDTH-1:0]                           imem_wdata,
    output logic [NUM_OF_REGS-1:0][$clog2(NUM_OF_REGS+3)-1:0] reg_in_sel,
    output logic [NUM_OF_REGS-1:0]                           reg_wr_en,
    output logic [$clog2(NUM_OF_REGS)-1:0]                   op_in1_sel,
    output logic [$clog2(NUM_OF_REGS)-1:0]                   op_in2_sel,
    output logic [$clog2(NUM_OF_REGS)-1:0]                   cond_rd_sel,
    input  logic [DATA_WIDTH-1:0]                            cond_rd_data,
    output logic [$clog2(IMEM_DEPTH)-1:0]                    pc_out
);

    localparam int unsigned PCW = $clog2(IMEM_DEPTH);
    localparam int unsigned RW  = $clog2(NUM_OF_REGS);
    localparam int unsigned CW  = $clog2(NUM_OF_REGS + 3);

    localparam logic [7:0]    NREGS8   = 8'(NUM_OF_REGS);
    localparam logic [CW-1:0] SEL_ADD  = CW'(NUM_OF_REGS + (ADDER_IDX   - CPUC_NUM_REGS));
    localparam logic [CW-1:0] SEL_GT   = CW'(NUM_OF_REGS + (GREATER_IDX - CPUC_NUM_REGS));
    localparam logic [CW-1:0] SEL_EQ   = CW'(NUM_OF_REGS + (EQUAL_IDX   - CPUC_NUM_REGS));

    t_seq_state       state_q, state_d;
    logic [PCW-1:0]   pc_q, pc_d;
    t_cpuc_instr      instr_q, instr_d;
    logic             error_q, error_d;

    logic [INSTR_WIDTH-1:0] imem_rdata;
    t_cpuc_instr            fetched;
    logic                   fetched_bad;
    logic [PCW-1:0]         pc_inc;
    logic [15:0]            tgt_full;
    logic [PCW-1:0]         target;
    logic [RW-1:0]          dst_idx, a_idx, b_idx;
    logic [CW-1:0]          unit_sel;

    // Program writes are refused while a program runs so the running code
    // cannot be modified under the sequencer.
    cpuc_imem #(
        .DEPTH  (IMEM_DEPTH),
        .WIDTH  (INSTR_WIDTH),
        .ADDR_W (PCW)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we && (state_q == S_IDLE)),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q),
        .rdata (imem_rdata)
    );

    assign fetched     = t_cpuc_instr'(imem_rdata);
    assign fetched_bad = cpuc_illegal(fetched, NREGS8);

    assign pc_inc   = pc_q + 1'b1;             // wraps at IMEM_DEPTH
    assign tgt_full = {instr_q.a, instr_q.b};
    assign target   = tgt_full[PCW-1:0];
    assign dst_idx  = instr_q.dst[RW-1:0];
    assign a_idx    = instr_q.a[RW-1:0];
    assign b_idx    = instr_q.b[RW-1:0];

    // Upper field bits are only meaningful to the legality check in DECODE.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr_q, tgt_full};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        error_d = error_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    error_d = 1'b0;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = fetched;
                if (fetched_bad) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (instr_q.op)
                    OP_JMP:  pc_d = target;
                    OP_BNZ:  if (cond_rd_data != '0) pc_d = target;
                    OP_HALT: begin
                        state_d = S_DONE;
                        pc_d    = pc_q;
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grid controls are pure decode of state and the latched instruction, so
    // an asynchronous reset removes them immediately.
    always_comb begin
        reg_wr_en   = '0;
        reg_in_sel  = '0;
        op_in1_sel  = '0;
        op_in2_sel  = '0;
        cond_rd_sel = '0;
        unit_sel    = '0;
        if (state_q == S_EXEC) begin
            case (instr_q.op)
                OP_MOV, OP_ADD, OP_GT, OP_EQ: begin
                    case (instr_q.op)
                        OP_ADD:  unit_sel = SEL_ADD;
                        OP_GT:   unit_sel = SEL_GT;
                        OP_EQ:   unit_sel = SEL_EQ;
                        default: unit_sel = CW'(a_idx);
                    endcase
                    reg_wr_en[dst_idx]  = 1'b1;
                    reg_in_sel[dst_idx] = unit_sel;
                    op_in1_sel          = a_idx;
                    op_in2_sel          = b_idx;
                end
                OP_BNZ: begin
                    cond_rd_sel = a_idx;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign done   = (state_q == S_DONE);
    assign error  = error_q;
    assign pc_out = pc_q;

endmodule

// File: tb/tb_cpuc_seq_ctrl.sv
module tb_cpuc_seq_ctrl;

    logic            clk;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic            error;
    logic            imem_we;
    logic [5:0]      imem_waddr;
    logic [31:0]     imem_wdata;
    logic [7:0][3:0] reg_in_sel;
    logic [7:0]      reg_wr_en;
    logic [2:0]      op_in1_sel;
    logic [2:0]      op_in2_sel;
    logic [2:0]      cond_rd_sel;
    logic [31:0]     cond_rd_data;
    logic [5:0]      pc_out;

    int total = 0;
    int bad   = 0;

    cpuc_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .reg_in_sel   (reg_in_sel),
        .reg_wr_en    (reg_wr_en),
        .op_in1_sel   (op_in1_sel),
        .op_in2_sel   (op_in2_sel),
        .cond_rd_sel  (cond_rd_sel),
        .cond_rd_data (cond_rd_data),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int op, input int dst, input int a, input int b);
        return {4'(op), 8'(dst), 8'(a), 8'(b), 4'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) step();
    endtask

    task automatic load(input logic [5:0] addr, input logic [31:0] w);
        imem_we = 1'b1; imem_waddr = addr; imem_wdata = w;
        step();
        imem_we = 1'b0;
    endtask

    // Leaves the bench in cycle 1 (FETCH of the first instruction).
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        skip(2);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", error); end
        total++; if (pc_out !== 6'd0) begin bad++; $display("FAIL reset_pc: got %0d want 0", pc_out); end
        total++; if (reg_wr_en !== 8'h00) begin bad++; $display("FAIL reset_wr_en: got %h want 00", reg_wr_en); end
        total++; if (reg_in_sel !== 32'h0) begin bad++; $display("FAIL reset_in_sel: got %h want 0", reg_in_sel); end
        total++; if ({op_in1_sel, op_in2_sel, cond_rd_sel} !== 9'h0) begin bad++; $display("FAIL reset_sels: got %h want 0", {op_in1_sel, op_in2_sel, cond_rd_sel}); end
        rst = 1'b1;
        step();
    endtask

    // MOV r1<-r0 ; ADD r2<-r1+r0 ; HALT
    task automatic test_basic();
        load(0, enc(1, 1, 0, 0));
        load(1, enc(2, 2, 1, 0));
        load(2, enc(7, 0, 0, 0));
        launch();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
        skip(2);
        total++; if (reg_wr_en !== 8'h02) begin bad++; $display("FAIL basic_mov_wr: got %h want 02", reg_wr_en); end
        total++; if (reg_in_sel[1] !== 4'd0) begin bad++; $display("FAIL basic_mov_sel: got %0d want 0", reg_in_sel[1]); end
        step();
        total++; if (reg_wr_en !== 8'h00) begin bad++; $display("FAIL basic_fetch_wr: got %h want 00", reg_wr_en); end
        skip(2);
        total++; if (reg_wr_en !== 8'h04) begin bad++; $display("FAIL basic_add_wr: got %h want 04", reg_wr_en); end
        total++; if (reg_in_sel[2] !== 4'd8) begin bad++; $display("FAIL basic_add_sel: got %0d want 8", reg_in_sel[2]); end
        total++; if (op_in1_sel !== 3'd1 || op_in2_sel !== 3'd0) begin bad++; $display("FAIL basic_add_ops: got %0d/%0d want 1/0", op_in1_sel, op_in2_sel); end
        skip(3);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_pre_done: got done=%b busy=%b want 0/1", done, busy); end
        step();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done: got done=%b busy=%b want 1/0", done, busy); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset_mid_exec();
        launch();
        skip(5);
        total++; if (reg_wr_en !== 8'h04) begin bad++; $display("FAIL rstmid_pre: got %h want 04", reg_wr_en); end
        #2 rst = 1'b0;
        #1;
        total++; if (reg_wr_en !== 8'h00) begin bad++; $display("FAIL rstmid_wr_en: got %h want 00", reg_wr_en); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_state: got busy=%b done=%b want 0/0", busy, done); end
        total++; if (pc_out !== 6'd0) begin bad++; $display("FAIL rstmid_pc: got %0d want 0", pc_out); end
        skip(2);
        rst = 1'b1;
        step();
        launch();
        skip(2);
        total++; if (reg_wr_en !== 8'h02) begin bad++; $display("FAIL rstmid_rerun_mov: got %h want 02", reg_wr_en); end
        skip(3);
        total++; if (reg_wr_en !== 8'h04 || reg_in_sel[2] !== 4'd8) begin bad++; $display("FAIL rstmid_rerun_add: got %h/%0d want 04/8", reg_wr_en, reg_in_sel[2]); end
        skip(4);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rstmid_rerun_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_busy_ignore();
        load(0, enc(1, 1, 0, 0));
        load(1, enc(7, 0, 0, 0));
        launch();
        for (int c = 1; c <= 5; c++) begin
            start = 1'b1; imem_we = 1'b1; imem_waddr = 6'd0; imem_wdata = enc(9, 0, 0, 0);
            if (c == 3) begin
                total++; if (reg_wr_en !== 8'h02) begin bad++; $display("FAIL busy_mov_wr: got %h want 02", reg_wr_en); end
            end
            step();
        end
        start = 1'b0; imem_we = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_still: got %b want 1", busy); end
        step();
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL busy_done: got done=%b err=%b want 1/0", done, error); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle: got %b want 0", busy); end
        launch();
        skip(2);
        total++; if (reg_wr_en !== 8'h02) begin bad++; $display("FAIL busy_readback_mov: got %h want 02", reg_wr_en); end
        skip(4);
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL busy_readback_done: got done=%b err=%b want 1/0", done, error); end
        step();
    endtask

    // GT r3<-r4>r5 ; EQ r7<-r6==r2 ; HALT
    task automatic test_units();
        load(0, enc(3, 3, 4, 5));
        load(1, enc(4, 7, 6, 2));
        load(2, enc(7, 0, 0, 0));
        launch();
        skip(2);
        total++; if (reg_wr_en !== 8'h08 || reg_in_sel[3] !== 4'd9) begin bad++; $display("FAIL units_gt: got %h/%0d want 08/9", reg_wr_en, reg_in_sel[3]); end
        total++; if (op_in1_sel !== 3'd4 || op_in2_sel !== 3'd5 || cond_rd_sel !== 3'd0) begin bad++; $display("FAIL units_gt_ops: got %0d/%0d/%0d want 4/5/0", op_in1_sel, op_in2_sel, cond_rd_sel); end
        skip(3);
        total++; if (reg_wr_en !== 8'h80 || reg_in_sel[7] !== 4'd10) begin bad++; $display("FAIL units_eq: got %h/%0d want 80/10", reg_wr_en, reg_in_sel[7]); end
        total++; if (op_in1_sel !== 3'd6 || op_in2_sel !== 3'd2) begin bad++; $display("FAIL units_eq_ops: got %0d/%0d want 6/2", op_in1_sel, op_in2_sel); end
        skip(4);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL units_done: got %b want 1", done); end
        step();
    endtask

    // BNZ r3 -> 5 at address 0, HALT at 1 and 5
    task automatic test_bnz();
        load(0, enc(6, 0, 3, 5));
        load(1, enc(7, 0, 0, 0));
        load(5, enc(7, 0, 0, 0));
        cond_rd_data = 32'd7;
        launch();
        step();
        total++; if (cond_rd_sel !== 3'd0) begin bad++; $display("FAIL bnz_decode_sel: got %0d want 0", cond_rd_sel); end
        step();
        total++; if (cond_rd_sel !== 3'd3 || reg_wr_en !== 8'h00) begin bad++; $display("FAIL bnz_exec: got sel=%0d wr=%h want 3/00", cond_rd_sel, reg_wr_en); end
        step();
        total++; if (pc_out !== 6'd5) begin bad++; $display("FAIL bnz_taken_pc: got %0d want 5", pc_out); end
        skip(3);
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL bnz_taken_done: got done=%b err=%b want 1/0", done, error); end
        step();
        cond_rd_data = 32'd0;
        launch();
        skip(3);
        total++; if (pc_out !== 6'd1) begin bad++; $display("FAIL bnz_not_taken_pc: got %0d want 1", pc_out); end
        skip(3);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL bnz_not_taken_done: got %b want 1", done); end
        step();
    endtask

    // JMP 63 at address 0, NOP at 63: endless loop across the PC wrap.
    task automatic test_jmp_wrap();
        load(0, enc(5, 0, 0, 63));
        load(63, enc(0, 0, 0, 0));
        launch();
        for (int c = 1; c <= 12; c++) begin
            total++; if (pc_out !== 6'd0 && pc_out !== 6'd63) begin bad++; $display("FAIL jmp_pc_range c%0d: got %0d want 0 or 63", c, pc_out); end
            if (c == 4) begin
                total++; if (pc_out !== 6'd63) begin bad++; $display("FAIL jmp_target: got %0d want 63", pc_out); end
            end
            if (c == 7) begin
                total++; if (pc_out !== 6'd0) begin bad++; $display("FAIL jmp_wrap: got %0d want 0", pc_out); end
            end
            if (c == 10) begin
                total++; if (pc_out !== 6'd63) begin bad++; $display("FAIL jmp_again: got %0d want 63", pc_out); end
            end
            step();
        end
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL jmp_running: got busy=%b done=%b want 1/0", busy, done); end
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || pc_out !== 6'd0) begin bad++; $display("FAIL jmp_stop: got busy=%b pc=%0d want 0/0", busy, pc_out); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_illegal();
        load(0, enc(9, 0, 0, 0));
        launch();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ill_op_early: got %b want 0", error); end
        step();
        total++; if (reg_wr_en !== 8'h00 || done !== 1'b0) begin bad++; $display("FAIL ill_op_decode: got wr=%h done=%b want 00/0", reg_wr_en, done); end
        step();
        total++; if (done !== 1'b1 || error !== 1'b1 || reg_wr_en !== 8'h00) begin bad++; $display("FAIL ill_op_done: got done=%b err=%b wr=%h want 1/1/00", done, error, reg_wr_en); end
        step();
        total++; if (done !== 1'b0 || error !== 1'b1) begin bad++; $display("FAIL ill_op_sticky: got done=%b err=%b want 0/1", done, error); end
        load(0, enc(2, 8, 0, 1));
        launch();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ill_dst_clear: got %b want 0", error); end
        skip(2);
        total++; if (done !== 1'b1 || error !== 1'b1 || reg_wr_en !== 8'h00) begin bad++; $display("FAIL ill_dst_done: got done=%b err=%b wr=%h want 1/1/00", done, error, reg_wr_en); end
        step();
        load(0, enc(7, 0, 0, 0));
        launch();
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ill_restart_clear: got %b want 0", error); end
        skip(3);
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL ill_halt_done: got done=%b err=%b want 1/0", done, error); end
        step();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; cond_rd_data = '0;
        test_reset();
        test_basic();
        test_reset_mid_exec();
        test_busy_ignore();
        test_units();
        test_bnz();
        test_jmp_wrap();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
